regfile_mp: RTL

- Parametrised multi-port register file for the single-cycle/pipelined datapath.
- Supplies operands for the ALU and write-back on one clock edge (posedge only).
- Registered read ports, two write ports with fixed priority, and optional write-to-read bypass.
- Optional hard-wired zero register; full asynchronous clear on reset.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 51 +++++
 rtl/regfile_mp.sv | 78 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and address-validity helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned ZERO_ADDR  = 0;

  // An address is usable when it is inside the file and is not the hard-wired zero entry.
  function automatic logic addr_valid(input int unsigned addr,
                                      input int unsigned depth,
                                      input bit          zero_reg);
    return (addr < depth) && !(zero_reg && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read lane: zero/out-of-range masking, optional write bypass, output flop.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic [DEPTH*DATA_W-1:0] mem_i,
  input  logic [1:0]              wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr0_i,
  input  logic [DATA_W-1:0]       wr_data0_i,
  input  logic [ADDR_W-1:0]       wr_addr1_i,
  input  logic [DATA_W-1:0]       wr_data1_i,
  output logic [DATA_W-1:0]       rd_data_o
);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // A valid read address implies a matching write address is valid too,
  // so the raw write enables are sufficient for the bypass match.
  always_comb begin
    stored = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (32'(rd_addr_i) == e) stored = mem_i[e*DATA_W +: DATA_W];
    end
    rd_data_d = '0;
    if (addr_valid(32'(rd_addr_i), DEPTH, ZERO_REG)) begin
      rd_data_d = stored;
      if (BYPASS) begin
        if (wr_en_i[1] && (wr_addr1_i == rd_addr_i))      rd_data_d = wr_data1_i;
        else if (wr_en_i[0] && (wr_addr0_i == rd_addr_i)) rd_data_d = wr_data0_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: flop storage, two prioritised write ports, NUM_RD registered reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEF_DATA_W,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned NUM_RD   = 2,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  output logic                     wr_collide
);

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic                    we0, we1;
  logic                    collide_d, collide_q;

  assign we0       = wr_en[0] && addr_valid(32'(wr_addr0), DEPTH, ZERO_REG);
  assign we1       = wr_en[1] && addr_valid(32'(wr_addr1), DEPTH, ZERO_REG);
  assign collide_d = we0 && we1 && (wr_addr0 == wr_addr1);

  // Port 1 is checked first so it wins a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (we1 && (32'(wr_addr1) == e))      mem_q[e] <= wr_data1;
        else if (we0 && (32'(wr_addr0) == e)) mem_q[e] <= wr_data0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collide_q <= 1'b0;
    else     collide_q <= collide_d;
  end

  assign wr_collide = collide_q;

  always_comb begin
    mem_flat = '0;
    for (int unsigned e = 0; e < DEPTH; e++) mem_flat[e*DATA_W +: DATA_W] = mem_q[e];
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .ADDR_W   (ADDR_W)
    ) u_rd (
      .clk        (clk),
      .rst        (rst),
      .rd_addr_i  (rd_addr[i*ADDR_W +: ADDR_W]),
      .mem_i      (mem_flat),
      .wr_en_i    (wr_en),
      .wr_addr0_i (wr_addr0),
      .wr_data0_i (wr_data0),
      .wr_addr1_i (wr_addr1),
      .wr_data1_i (wr_data1),
      .rd_data_o  (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule
